// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : shared types and constants for the AES input loader
// Revision: 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int   WORDS    = 128 / 32;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_KEY  = 3'd1,
    LD_TEXT = 3'd2,
    ISSUE   = 3'd3,
    BUSY    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_word_packer : block register filled one word at a time; word 0 is the MSW
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  localparam int NW    = BLK_W / WORD_W,
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] data,
  output logic [BLK_W-1:0]  blk
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
    end else if (wr) begin
      for (int k = 0; k < NW; k++) begin
        if (idx == IDX_W'(k)) begin
          blk[BLK_W-1-k*WORD_W -: WORD_W] <= data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_input_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_input_loader : assembles key/text blocks from a host word stream and
//                    issues one Start per block to the AES round controller
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_keynew,
  input  logic              in_mode,
  input  logic              eng_done,
  output logic              Start,
  output logic              Select,
  output logic [BLK_W-1:0]  key_out,
  output logic [BLK_W-1:0]  text_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err_nokey,
  output logic              err_timeout
);

  localparam int NW    = BLK_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state, next;
  logic [IDX_W-1:0] cnt;
  logic             mode_q;
  logic             keynew_q;
  logic             accept;
  logic             last;
  logic             expire;
  logic             key_wr;
  logic             text_wr;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == IDX_W'(NW - 1));
  assign Select = mode_q;

  // The beat counter is zero in IDLE, so it doubles as the word index for both packers.
  assign key_wr  = accept && ((state == IDLE && in_keynew) || state == LD_KEY);
  assign text_wr = accept && ((state == IDLE && !in_keynew) || state == LD_TEXT);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [WD_W-1:0] wdog;

      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          wdog <= '0;
        end else if (state == ISSUE) begin
          wdog <= '0;
        end else if (state == BUSY) begin
          wdog <= wdog + 1'b1;
        end
      end

      // Fires during the TIMEOUT-th cycle spent in BUSY.
      assign expire = (state == BUSY) && (wdog == WD_W'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = in_keynew ? LD_KEY : LD_TEXT;
      LD_KEY:  if (accept && last) next = LD_TEXT;
      LD_TEXT: if (accept && last) next = (key_valid || keynew_q) ? ISSUE : IDLE;
      ISSUE:   next = BUSY;
      BUSY:    if (eng_done || expire) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    Start    = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE, LD_KEY, LD_TEXT: in_ready = 1'b1;
      ISSUE: begin
        Start = 1'b1;
        busy  = 1'b1;
      end
      BUSY:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      mode_q      <= MODE_ENC;
      keynew_q    <= 1'b0;
      key_valid   <= 1'b0;
      err_nokey   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_nokey   <= 1'b0;
      // A done arriving in the expiry cycle wins over the watchdog.
      err_timeout <= expire && !eng_done;
      if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == IDLE) begin
          mode_q   <= in_mode;
          keynew_q <= in_keynew;
        end
        if (state == LD_TEXT && last) begin
          if (key_valid || keynew_q) begin
            key_valid <= 1'b1;
          end else begin
            err_nokey <= 1'b1;
          end
        end
      end
    end
  end

  aes_word_packer #(
    .WORD_W (WORD_W),
    .BLK_W  (BLK_W)
  ) u_key_packer (
    .clk  (CLK),
    .rst  (reset),
    .wr   (key_wr),
    .idx  (cnt),
    .data (in_data),
    .blk  (key_out)
  );

  aes_word_packer #(
    .WORD_W (WORD_W),
    .BLK_W  (BLK_W)
  ) u_text_packer (
    .clk  (CLK),
    .rst  (reset),
    .wr   (text_wr),
    .idx  (cnt),
    .data (in_data),
    .blk  (text_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_aes_input_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_input_loader : directed and randomized checks of the AES input loader
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aes_input_loader;

  logic         CLK = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_keynew;
  logic         in_mode;
  logic         eng_done;
  logic         Start;
  logic         Select;
  logic [127:0] key_out;
  logic [127:0] text_out;
  logic         key_valid;
  logic         busy;
  logic         err_nokey;
  logic         err_timeout;

  int tests = 0;
  int fails = 0;

  logic [127:0] m_key  = '0;
  logic [127:0] m_text = '0;
  logic         m_kv   = 1'b0;

  localparam logic [127:0] KEY1  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] TEXT1 = 128'h3243f6a8_885a308d_313198a2_e0370734;

  aes_input_loader #(
    .WORD_W  (32),
    .BLK_W   (128),
    .TIMEOUT (64)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_keynew   (in_keynew),
    .in_mode     (in_mode),
    .eng_done    (eng_done),
    .Start       (Start),
    .Select      (Select),
    .key_out     (key_out),
    .text_out    (text_out),
    .key_valid   (key_valid),
    .busy        (busy),
    .err_nokey   (err_nokey),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic kn, input logic md, input int maxgap);
    int  g;
    logic acc;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    in_valid = 1'b0;
    for (int i = 0; i < g; i++) begin
      in_data = $urandom;
      step();
    end
    in_data   = d;
    in_keynew = kn;
    in_mode   = md;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    tests++;
    fails++;
    $error("FAIL beat_accept: observed no acceptance within 50 cycles, expected acceptance");
  endtask

  // Sends a whole frame, then checks the cycle after the last beat.
  task automatic run_frame(input logic kn, input logic md, input logic [127:0] k,
                           input logic [127:0] t, input int maxgap);
    int          n;
    logic [31:0] w;
    n = kn ? 8 : 4;
    for (int b = 0; b < n; b++) begin
      if (kn && b < 4) w = k[127-32*b -: 32];
      else             w = t[127-32*(kn ? b-4 : b) -: 32];
      send_beat(w, (b == 0) ? kn : 1'($urandom), (b == 0) ? md : 1'($urandom), maxgap);
    end
    if (kn || m_kv) begin
      if (kn) m_key = k;
      m_text = t;
      m_kv   = 1'b1;
      chk("start_pulse", Start, 1'b1);
      chk("select", Select, md);
      chk("ready_low_issue", in_ready, 1'b0);
      chk("busy_issue", busy, 1'b1);
      chk("key_out", key_out, m_key);
      chk("text_out", text_out, m_text);
      chk("key_valid", key_valid, 1'b1);
      chk("no_err_nokey", err_nokey, 1'b0);
    end else begin
      chk("err_nokey_pulse", err_nokey, 1'b1);
      chk("no_start_nokey", Start, 1'b0);
      chk("ready_after_nokey", in_ready, 1'b1);
      chk("key_valid_nokey", key_valid, 1'b0);
      step();
      chk("err_nokey_once", err_nokey, 1'b0);
      chk("no_start_later", Start, 1'b0);
    end
  endtask

  // Entered in the Start cycle; holds BUSY for a while then completes with eng_done.
  task automatic finish_busy(input logic md, input logic done_in_issue, input int hold);
    eng_done = done_in_issue;
    step();
    eng_done = 1'b0;
    chk("start_one_cycle", Start, 1'b0);
    chk("busy_after_issue", busy, 1'b1);
    for (int i = 0; i < hold; i++) step();
    chk("busy_held", busy, 1'b1);
    chk("ready_low_busy", in_ready, 1'b0);
    chk("select_held", Select, md);
    chk("key_stable", key_out, m_key);
    chk("text_stable", text_out, m_text);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("ready_after_done", in_ready, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    chk("no_timeout_on_done", err_timeout, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_key  = '0;
    m_text = '0;
    m_kv   = 1'b0;
  endtask

  initial begin
    int           n;
    logic [127:0] rk, rt;
    logic         kn, md;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keynew = 1'b0;
    in_mode   = 1'b0;
    eng_done  = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_start", Start, 1'b0);
    chk("rst_select", Select, 1'b0);
    chk("rst_key", key_out, '0);
    chk("rst_text", text_out, '0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errs", {err_nokey, err_timeout}, 2'b00);
    reset = 1'b0;

    // Known-answer frame with key, encrypt
    run_frame(1'b1, 1'b0, KEY1, TEXT1, 0);
    finish_busy(1'b0, 1'b0, 5);

    // Text-only decrypt frame; done during ISSUE must be ignored
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_frame(1'b0, 1'b1, '0, rt, 0);
    finish_busy(1'b1, 1'b1, 10);

    // Text-only frame with no key loaded
    apply_reset();
    run_frame(1'b0, 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 0);

    // Watchdog expiry
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_frame(1'b1, 1'b1, rk, rt, 0);
    n = 0;
    step();
    while (busy && n < 200) begin
      n++;
      if (n == 63) chk("no_early_timeout", err_timeout, 1'b0);
      step();
    end
    chk("busy_cycles_to_timeout", n, 64);
    chk("err_timeout_pulse", err_timeout, 1'b1);
    chk("ready_after_timeout", in_ready, 1'b1);
    step();
    chk("err_timeout_once", err_timeout, 1'b0);
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_frame(1'b0, 1'b0, '0, rt, 0);
    finish_busy(1'b0, 1'b0, 3);

    // Asynchronous reset after beat 5 of a keyed frame
    rk = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 5; b++) begin
      send_beat((b < 4) ? rk[127-32*b -: 32] : 32'hdeadbeef, (b == 0) ? 1'b1 : 1'b0, 1'b1, 0);
    end
    reset = 1'b1;
    #2;
    chk("async_rst_key", key_out, '0);
    chk("async_rst_text", text_out, '0);
    chk("async_rst_kv", key_valid, 1'b0);
    chk("async_rst_outs", {Start, Select, busy, err_nokey, err_timeout}, 5'b0);
    chk("async_rst_ready", in_ready, 1'b1);
    step();
    reset = 1'b0;
    m_key  = '0;
    m_text = '0;
    m_kv   = 1'b0;
    step();
    chk("no_start_after_rst", Start, 1'b0);
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_frame(1'b1, 1'b0, rk, rt, 0);
    finish_busy(1'b0, 1'b0, 2);

    // Spurious done in IDLE, then the known-answer frame with random stalls
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("spurious_done_ready", in_ready, 1'b1);
    chk("spurious_done_busy", busy, 1'b0);
    run_frame(1'b1, 1'b0, KEY1, TEXT1, 4);
    chk("kat_key_gaps", key_out, KEY1);
    chk("kat_text_gaps", text_out, TEXT1);
    finish_busy(1'b0, 1'b0, 1);

    // Random frames against the reference model
    for (int it = 0; it < 6; it++) begin
      kn = 1'($urandom);
      md = 1'($urandom);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom, $urandom, $urandom};
      run_frame(kn, md, rk, rt, 3);
      finish_busy(md, 1'($urandom), int'($urandom_range(0, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
